// File: rtl/isa_pkg.sv
// ISA constants for the 5-bit-opcode instruction set shared by the decode/issue
// stage: opcode and ALU-op encodings, instruction format enum, the bit positions
// of the one-hot class flags, and small decode helpers.
package isa_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  typedef enum logic [1:0] {
    TYPE_R   = 2'd0,
    TYPE_I   = 2'd1,
    TYPE_JI  = 2'd2,
    TYPE_JII = 2'd3
  } instr_type_e;

  // Bit positions inside the 16-bit class flag vector (MSB = alu).
  localparam int CTRL_ALU   = 15;
  localparam int CTRL_ADD   = 14;
  localparam int CTRL_SUB   = 13;
  localparam int CTRL_MUL   = 12;
  localparam int CTRL_DIV   = 11;
  localparam int CTRL_ADDI  = 10;
  localparam int CTRL_J     = 9;
  localparam int CTRL_BNE   = 8;
  localparam int CTRL_JAL   = 7;
  localparam int CTRL_JR    = 6;
  localparam int CTRL_BLT   = 5;
  localparam int CTRL_SW    = 4;
  localparam int CTRL_LW    = 3;
  localparam int CTRL_BEX   = 2;
  localparam int CTRL_SETX  = 1;
  localparam int CTRL_RSVD0 = 0;

  // Class flags for an opcode/aluop pair; unknown opcodes raise no flag and
  // the reserved bit always stays low.
  function automatic logic [15:0] decode_ctrl(input logic [4:0] op, input logic [4:0] aluop);
    logic [15:0] ctrl;
    ctrl = '0;
    case (op)
      OP_ALU: begin
        ctrl[CTRL_ALU] = 1'b1;
        ctrl[CTRL_ADD] = (aluop == ALU_ADD);
        ctrl[CTRL_SUB] = (aluop == ALU_SUB);
        ctrl[CTRL_MUL] = (aluop == ALU_MUL);
        ctrl[CTRL_DIV] = (aluop == ALU_DIV);
      end
      OP_J:    ctrl[CTRL_J]    = 1'b1;
      OP_BNE:  ctrl[CTRL_BNE]  = 1'b1;
      OP_JAL:  ctrl[CTRL_JAL]  = 1'b1;
      OP_JR:   ctrl[CTRL_JR]   = 1'b1;
      OP_ADDI: ctrl[CTRL_ADDI] = 1'b1;
      OP_BLT:  ctrl[CTRL_BLT]  = 1'b1;
      OP_SW:   ctrl[CTRL_SW]   = 1'b1;
      OP_LW:   ctrl[CTRL_LW]   = 1'b1;
      OP_SETX: ctrl[CTRL_SETX] = 1'b1;
      OP_BEX:  ctrl[CTRL_BEX]  = 1'b1;
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

  // Instruction format from the opcode; unknown opcodes are reported as R.
  function automatic instr_type_e decode_type(input logic [4:0] op);
    instr_type_e t;
    case (op)
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: t = TYPE_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:         t = TYPE_JI;
      OP_JR:                                 t = TYPE_JII;
      default:                               t = TYPE_R;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues, cleared by writeback ports or when a killed writer releases
// its destination. Register 0 can never be pending.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int NUM_WB   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [REG_AW-1:0]        set_reg,
  input  logic [NUM_WB-1:0]        clr_valid,
  input  logic [NUM_WB*REG_AW-1:0] clr_reg,
  input  logic                     rel_en,
  input  logic [REG_AW-1:0]        rel_reg,
  output logic [NUM_REGS-1:0]      sb
);

  logic [NUM_REGS-1:0] sb_next;

  // Clears first, then the new writer's set wins; bit 0 is forced low last.
  always_comb begin
    sb_next = sb;
    for (int k = 0; k < NUM_WB; k++) begin
      if (clr_valid[k]) sb_next[clr_reg[k*REG_AW +: REG_AW]] = 1'b0;
    end
    if (rel_en) sb_next[rel_reg] = 1'b0;
    if (set_en) sb_next[set_reg] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Registered decode/issue stage: decodes the fetched word, stalls on RAW/WAW
// hazards against the scoreboard and on a busy mul/div unit, and issues into a
// one-entry output register with valid/ready flow control and flush.
// Optional: define DECODE_SKID_EN for a one-entry input skid buffer that makes
// in_ready a registered signal.
module decode_issue_scoreboard
  import isa_pkg::*;
#(
  parameter int PC_W          = 32,
  parameter int NUM_REGS      = 32,
  parameter int REG_AW        = $clog2(NUM_REGS),
  parameter int NUM_WB        = 2,
  parameter int MULDIV_CYCLES = 32,
  parameter int LINK_REG      = 31,
  parameter int STATUS_REG    = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [1:0]               out_type,
  output logic [15:0]              out_ctrl,
  output logic                     out_wr_en,
  output logic [REG_AW-1:0]        out_wr_reg,
  output logic [REG_AW-1:0]        out_src_a,
  output logic [REG_AW-1:0]        out_src_b,
  output logic                     out_use_a,
  output logic                     out_use_b,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*REG_AW-1:0] wb_reg,
  input  logic                     flush,
  output logic [15:0]              stall_cnt
);

  localparam int MD_W = $clog2(MULDIV_CYCLES + 1);

  logic              cand_valid;
  logic [31:0]       cand_instr;
  logic [PC_W-1:0]   cand_pc;
  logic [15:0]       dec_ctrl;
  instr_type_e       dec_type;
  logic [REG_AW-1:0] dec_rd, dec_src_a, dec_src_b, dec_wr_reg;
  logic              dec_use_a, dec_use_b, dec_wr_en, dec_muldiv;
  logic [NUM_REGS-1:0] sb_vec;
  logic [MD_W-1:0]   md_cnt;
  logic              md_busy, hazard, can_issue, issue, fire, kill;

`ifdef DECODE_SKID_EN
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;

  assign cand_valid = skid_valid | in_valid;
  assign cand_instr = skid_valid ? skid_instr : in_instr;
  assign cand_pc    = skid_valid ? skid_pc : in_pc;
  assign in_ready   = !skid_valid;

  // Park a word that arrives while issue is blocked; it issues before anything newer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (skid_valid) begin
      if (can_issue) skid_valid <= 1'b0;
    end else if (in_valid && !can_issue) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end
`else
  assign cand_valid = in_valid;
  assign cand_instr = in_instr;
  assign cand_pc    = in_pc;
  assign in_ready   = can_issue;
`endif

  // Field extraction and operand/destination selection for the candidate word.
  always_comb begin
    dec_ctrl   = decode_ctrl(cand_instr[31:27], cand_instr[6:2]);
    dec_type   = decode_type(cand_instr[31:27]);
    dec_rd     = REG_AW'(cand_instr[26:22]);
    dec_src_a  = dec_ctrl[CTRL_BEX] ? REG_AW'(STATUS_REG) : REG_AW'(cand_instr[21:17]);
    dec_src_b  = (dec_ctrl[CTRL_BNE] | dec_ctrl[CTRL_BLT] | dec_ctrl[CTRL_JR])
                 ? dec_rd : REG_AW'(cand_instr[16:12]);
    dec_wr_reg = dec_ctrl[CTRL_JAL]  ? REG_AW'(LINK_REG) :
                 dec_ctrl[CTRL_SETX] ? REG_AW'(STATUS_REG) : dec_rd;
    dec_use_a  = dec_ctrl[CTRL_ALU] | dec_ctrl[CTRL_ADDI] | dec_ctrl[CTRL_SW] | dec_ctrl[CTRL_LW] |
                 dec_ctrl[CTRL_BNE] | dec_ctrl[CTRL_BLT] | dec_ctrl[CTRL_BEX];
    dec_use_b  = (dec_ctrl[CTRL_ALU] & (cand_instr[6:2] != 5'd8) & (cand_instr[6:2] != 5'd9)) |
                 dec_ctrl[CTRL_BNE] | dec_ctrl[CTRL_BLT] | dec_ctrl[CTRL_JR];
    dec_wr_en  = (dec_ctrl[CTRL_ALU] | dec_ctrl[CTRL_ADDI] | dec_ctrl[CTRL_LW] |
                  dec_ctrl[CTRL_JAL] | dec_ctrl[CTRL_SETX]) & (dec_wr_reg != '0);
    dec_muldiv = dec_ctrl[CTRL_MUL] | dec_ctrl[CTRL_DIV];
  end

  assign md_busy   = (md_cnt != '0) | (out_valid & (out_ctrl[CTRL_MUL] | out_ctrl[CTRL_DIV]));
  assign hazard    = (dec_use_a & sb_vec[dec_src_a]) | (dec_use_b & sb_vec[dec_src_b]) |
                     (dec_wr_en & sb_vec[dec_wr_reg]) | (dec_muldiv & md_busy);
  assign can_issue = !hazard & (!out_valid | out_ready) & !flush;
  assign issue     = cand_valid & can_issue;
  assign fire      = out_valid & out_ready & !flush;
  assign kill      = out_valid & flush;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .NUM_WB   (NUM_WB)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_en    (issue & dec_wr_en),
    .set_reg   (dec_wr_reg),
    .clr_valid (wb_valid),
    .clr_reg   (wb_reg),
    .rel_en    (kill & out_wr_en),
    .rel_reg   (out_wr_reg),
    .sb        (sb_vec)
  );

  // Output register: load on issue, drop valid on retire or flush, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_type   <= '0;
      out_ctrl   <= '0;
      out_wr_en  <= 1'b0;
      out_wr_reg <= '0;
      out_src_a  <= '0;
      out_src_b  <= '0;
      out_use_a  <= 1'b0;
      out_use_b  <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_instr  <= cand_instr;
      out_pc     <= cand_pc;
      out_type   <= dec_type;
      out_ctrl   <= dec_ctrl;
      out_wr_en  <= dec_wr_en;
      out_wr_reg <= dec_wr_reg;
      out_src_a  <= dec_src_a;
      out_src_b  <= dec_src_b;
      out_use_a  <= dec_use_a;
      out_use_b  <= dec_use_b;
    end else if (fire || flush) begin
      out_valid  <= 1'b0;
    end
  end

  // Mul/div busy timer starts when execute accepts a mul/div and runs to zero even across a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                            md_cnt <= '0;
    else if (fire && (out_ctrl[CTRL_MUL] || out_ctrl[CTRL_DIV])) md_cnt <= MD_W'(MULDIV_CYCLES);
    else if (md_cnt != '0)                                md_cnt <= md_cnt - 1'b1;
  end

  // Saturating count of cycles where fetch offered a word that was refused.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                                stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Bench for decode_issue_scoreboard: directed scenarios with hand-computed
// literal expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the stage.
module tb_decode_issue_scoreboard;

  localparam int MDC = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  out_type;
  logic [15:0] out_ctrl;
  logic        out_wr_en;
  logic [4:0]  out_wr_reg, out_src_a, out_src_b;
  logic        out_use_a, out_use_b;
  logic [1:0]  wb_valid = '0;
  logic [9:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;

  always #5 clock = ~clock;

  decode_issue_scoreboard #(.MULDIV_CYCLES(MDC)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_type(out_type), .out_ctrl(out_ctrl), .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_use_a(out_use_a), .out_use_b(out_use_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .stall_cnt(stall_cnt)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct packed {
    logic [1:0]  itype;
    logic [15:0] ctrl;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        use_a;
    logic        use_b;
  } dec_t;

  // Reference decode written straight from the instruction-class rules.
  function automatic dec_t modelDecode(input logic [31:0] w);
    dec_t d;
    logic [4:0] op, aop, rd, rs, rt;
    bit isAlu, isAddi, isJ, isBne, isJal, isJr, isBlt, isSw, isLw, isBex, isSetx;
    op = w[31:27]; aop = w[6:2]; rd = w[26:22]; rs = w[21:17]; rt = w[16:12];
    isAlu = (op == 0); isJ = (op == 1); isBne = (op == 2); isJal = (op == 3); isJr = (op == 4);
    isAddi = (op == 5); isBlt = (op == 6); isSw = (op == 7); isLw = (op == 8);
    isSetx = (op == 21); isBex = (op == 22);
    d = '0;
    d.ctrl[15] = isAlu;
    d.ctrl[14] = isAlu && aop == 0;
    d.ctrl[13] = isAlu && aop == 1;
    d.ctrl[12] = isAlu && aop == 6;
    d.ctrl[11] = isAlu && aop == 7;
    d.ctrl[10] = isAddi; d.ctrl[9] = isJ; d.ctrl[8] = isBne; d.ctrl[7] = isJal;
    d.ctrl[6] = isJr; d.ctrl[5] = isBlt; d.ctrl[4] = isSw; d.ctrl[3] = isLw;
    d.ctrl[2] = isBex; d.ctrl[1] = isSetx;
    if (isAddi || isSw || isLw || isBne || isBlt) d.itype = 2'd1;
    else if (isJ || isJal || isSetx || isBex)     d.itype = 2'd2;
    else if (isJr)                                d.itype = 2'd3;
    else                                          d.itype = 2'd0;
    d.src_a  = isBex ? 5'd30 : rs;
    d.src_b  = (isBne || isBlt || isJr) ? rd : rt;
    d.use_a  = isAlu || isAddi || isSw || isLw || isBne || isBlt || isBex;
    d.use_b  = (isAlu && aop != 8 && aop != 9) || isBne || isBlt || isJr;
    d.wr_reg = isJal ? 5'd31 : (isSetx ? 5'd30 : rd);
    d.wr_en  = (isAlu || isAddi || isLw || isJal || isSetx) && d.wr_reg != 0;
    return d;
  endfunction

  // Model state: pending registers, output slot contents, mul/div free cycle.
  bit [31:0]   mPend = '0;
  bit          mValid = 1'b0;
  logic [31:0] mInstr = '0;
  logic [31:0] mPc = '0;
  dec_t        mDec = '0;
  int          cyc = 0;
  int          mdFreeAt = 0;
  int          mStall = 0;
  bit          accepted = 1'b0;
  bit          chkEn = 1'b0;

  function automatic bit modelReady();
    dec_t d;
    bit mdBusy, haz;
    d = modelDecode(in_instr);
    mdBusy = (cyc < mdFreeAt) || (mValid && (mDec.ctrl[12] || mDec.ctrl[11]));
    haz = (d.use_a && mPend[d.src_a]) || (d.use_b && mPend[d.src_b]) ||
          (d.wr_en && mPend[d.wr_reg]) || ((d.ctrl[12] || d.ctrl[11]) && mdBusy);
    return !haz && (!mValid || out_ready) && !flush;
  endfunction

  dec_t mNew;
  bit   mRdy, mIss, mFire;

  // Advance the model on each clock edge; reset wipes it immediately.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mPend = '0; mValid = 0; mInstr = '0; mPc = '0; mDec = '0;
      mdFreeAt = 0; mStall = 0; accepted = 0; cyc = 0;
    end else begin
      mRdy  = modelReady();
      mNew  = modelDecode(in_instr);
      mIss  = in_valid && mRdy;
      mFire = mValid && out_ready && !flush;
      accepted = mIss;
      if (in_valid && !mRdy && mStall < 65535) mStall++;
      if (mFire && (mDec.ctrl[12] || mDec.ctrl[11])) mdFreeAt = cyc + MDC + 1;
      for (int k = 0; k < 2; k++)
        if (wb_valid[k] && wb_reg[k*5 +: 5] != 0) mPend[wb_reg[k*5 +: 5]] = 1'b0;
      if (flush && mValid && mDec.wr_en) mPend[mDec.wr_reg] = 1'b0;
      if (mIss && mNew.wr_en) mPend[mNew.wr_reg] = 1'b1;
      if (mIss) begin
        mValid = 1; mInstr = in_instr; mPc = in_pc; mDec = mNew;
      end else if (mFire || flush) begin
        mValid = 0;
      end
      cyc++;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("in_ready",   in_ready,   modelReady());
    cmp("out_valid",  out_valid,  mValid);
    cmp("out_instr",  out_instr,  mInstr);
    cmp("out_pc",     out_pc,     mPc);
    cmp("out_type",   out_type,   mDec.itype);
    cmp("out_ctrl",   out_ctrl,   mDec.ctrl);
    cmp("out_wr_en",  out_wr_en,  mDec.wr_en);
    cmp("out_wr_reg", out_wr_reg, mDec.wr_reg);
    cmp("out_src_a",  out_src_a,  mDec.src_a);
    cmp("out_src_b",  out_src_b,  mDec.src_b);
    cmp("out_use_a",  out_use_a,  mDec.use_a);
    cmp("out_use_b",  out_use_b,  mDec.use_b);
    cmp("stall_cnt",  stall_cnt,  mStall);
  endtask

  // Every-cycle comparison against the model, midway between active edges.
  always @(negedge clock) if (chkEn) checkOutput();

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic sample();
    @(negedge clock); #1;
  endtask

  // Offer a word and hold it until accepted (bounded); returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] pc);
    int waited;
    in_valid = 1; in_instr = w; in_pc = pc;
    waited = 0;
    sample();
    while (!in_ready && waited < 200) begin
      tick(); sample(); waited++;
    end
    cmp("accept_wait", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  logic [4:0] regPool [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd30, 5'd31};
  logic [4:0] opPool  [14] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd9};
  logic [4:0] aopPool [7] = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd8, 5'd9, 5'd3};

  function automatic logic [31:0] randWord();
    return {opPool[$urandom_range(0, 13)], regPool[$urandom_range(0, 6)],
            regPool[$urandom_range(0, 6)], regPool[$urandom_range(0, 6)],
            5'($urandom), aopPool[$urandom_range(0, 6)], 2'($urandom)};
  endfunction

  initial begin
    int cnt;
    repeat (2) @(posedge clock);
    #2 reset = 0;
    chkEn = 1;
    sample();
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_out_instr", out_instr, 0);
    cmp("rst_out_ctrl",  out_ctrl, 0);
    cmp("rst_stall_cnt", stall_cnt, 0);

    // RAW stall on r3, released the cycle after its writeback.
    tick(); out_ready = 1; in_valid = 1; in_instr = 32'h00C22000; in_pc = 32'd100;
    sample(); cmp("raw_add_ready", in_ready, 1);
    tick(); in_instr = 32'h29060005; in_pc = 32'd104;
    sample();
    cmp("raw_add_ctrl", out_ctrl, 16'hC000);
    cmp("raw_add_wr_reg", out_wr_reg, 3);
    cmp("raw_addi_stalled", in_ready, 0);
    cmp("raw_stall0", stall_cnt, 0);
    tick(); wb_valid = 2'b01; wb_reg = {5'd0, 5'd3};
    sample();
    cmp("raw_wb_same_cycle", in_ready, 0);
    cmp("raw_stall1", stall_cnt, 1);
    tick(); wb_valid = 0;
    sample();
    cmp("raw_resume", in_ready, 1);
    cmp("raw_stall2", stall_cnt, 2);
    tick(); in_valid = 0;
    sample();
    cmp("addi_ctrl", out_ctrl, 16'h0400);
    cmp("addi_type", out_type, 1);
    cmp("addi_src_a", out_src_a, 3);

    // Structural stall: second mul waits MDC cycles after the first is dispatched.
    tick(); wb_valid = 2'b01; wb_reg = {5'd0, 5'd4};
    tick(); wb_valid = 0; in_valid = 1; in_instr = 32'h01422018; in_pc = 32'd200;
    sample(); cmp("mul1_ready", in_ready, 1);
    tick(); in_valid = 0;
    tick(); in_valid = 1; in_instr = 32'h01822018; in_pc = 32'd204;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (in_ready) break;
      cnt++;
      tick();
    end
    cmp("mul_stall_cycles", cnt, MDC);
    tick(); in_valid = 0; wb_valid = 2'b11; wb_reg = {5'd6, 5'd5};

    // Flush of a held jal releases r31.
    tick(); wb_valid = 0; out_ready = 0; in_valid = 1; in_instr = 32'h18000040; in_pc = 32'd300;
    sample(); cmp("jal_ready", in_ready, 1);
    tick(); in_valid = 0;
    sample();
    cmp("jal_wr_reg", out_wr_reg, 31);
    cmp("jal_ctrl", out_ctrl, 16'h0080);
    cmp("jal_type", out_type, 2);
    cmp("jal_sb31_set", dut.sb_vec[31], 1);
    tick(); flush = 1;
    sample(); cmp("flush_valid_holds", out_valid, 1);
    tick(); flush = 0; in_valid = 1; in_instr = 32'h27C00000; in_pc = 32'd304;
    sample();
    cmp("flush_valid_clear", out_valid, 0);
    cmp("flush_sb31_clear", dut.sb_vec[31], 0);
    cmp("jr_r31_ready", in_ready, 1);
    tick(); in_valid = 0; out_ready = 1;

    // Writes to r0 do not mark anything pending.
    tick(); in_valid = 1; in_instr = 32'h00022000; in_pc = 32'd400;
    sample(); cmp("r0_ready", in_ready, 1);
    tick(); in_instr = 32'h01800000; in_pc = 32'd404;
    sample();
    cmp("r0_wr_en", out_wr_en, 0);
    cmp("r0_no_stall", in_ready, 1);
    tick(); in_valid = 0;
    sample(); cmp("r6_wr_en", out_wr_en, 1);
    tick(); wb_valid = 2'b01; wb_reg = {5'd0, 5'd6};

    // Back-pressure: output fields hold while execute refuses them.
    tick(); wb_valid = 0; out_ready = 0; in_valid = 1; in_instr = 32'h01C22000; in_pc = 32'd500;
    sample(); cmp("hold_a_ready", in_ready, 1);
    tick(); in_instr = 32'h02022004; in_pc = 32'd504;
    for (int i = 0; i < 3; i++) begin
      sample();
      cmp("hold_in_ready", in_ready, 0);
      cmp("hold_out_instr", out_instr, 32'h01C22000);
      tick();
    end
    out_ready = 1;
    sample(); cmp("hold_release", in_ready, 1);
    tick(); in_valid = 0; wb_valid = 2'b11; wb_reg = {5'd8, 5'd7};
    sample(); cmp("hold_b_instr", out_instr, 32'h02022004);
    tick(); wb_valid = 0;

    // Reset while stalled on r3 with the mul/div timer running.
    applyStimulus(32'h00C22000, 32'd600);
    applyStimulus(32'h01422018, 32'd604);
    in_valid = 1; in_instr = 32'h29060005; in_pc = 32'd608;
    sample(); cmp("pre_rst_stall", in_ready, 0);
    repeat (5) tick();
    @(posedge clock); #3 reset = 1;
    #1;
    cmp("mid_rst_out_valid", out_valid, 0);
    cmp("mid_rst_out_instr", out_instr, 0);
    cmp("mid_rst_out_pc", out_pc, 0);
    cmp("mid_rst_wr_reg", out_wr_reg, 0);
    cmp("mid_rst_stall_cnt", stall_cnt, 0);
    cmp("mid_rst_sb", dut.sb_vec, 0);
    tick(); reset = 0;
    sample(); cmp("post_rst_ready", in_ready, 1);
    tick(); in_valid = 0;
    sample(); cmp("post_rst_issue", out_instr, 32'h29060005);
    tick(); wb_valid = 2'b01; wb_reg = {5'd0, 5'd4};

    // Randomized traffic checked by the every-cycle comparison.
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 9) < 8);
        in_instr = randWord();
        in_pc    = $urandom;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_valid  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      wb_reg    = {regPool[$urandom_range(0, 6)], regPool[$urandom_range(0, 6)]};
    end
    tick(); in_valid = 0; flush = 0; wb_valid = 0;
    sample();
    chkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
